mem_access_unit: RTL and testbench

- MEM-stage initiator for the word-addressed data memory of the MIPS core.
- Converts pipeline load/store requests (byte/half/word, signed/unsigned, byte address) into the memory's Rd/Wr/Addr/In_Data protocol.
- Sub-word stores use read-modify-write.
- Sign/zero-extends load data and stalls the pipeline until each access completes.

---
 rtl/mem_access_unit.sv | 145 ++++++++++++++
 tb/tb_mem_access_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for the word-addressed data memory.
// Turns byte/half/word load/store requests into Rd/Wr/Addr/In_Data cycles,
// performs read-modify-write for sub-word stores, extends load data and
// stalls the pipeline until each access has completed.
// Optional feature: define MEM_BIG_ENDIAN_EN for big-endian lane mapping.
//
// Handshake: a request is taken while req_valid=1 in IDLE; the pipeline holds
// the request stable while stall=1; completion is a one-cycle rsp_valid pulse
// (stall is low in that cycle so the pipeline advances on the same edge).
module mem_access_unit #(
    parameter int len_addr = 32,
    parameter int len_data = 32,
    parameter int RD_LAT   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [len_addr-1:0] req_addr,
    input  logic [len_data-1:0] req_wdata,
    output logic                stall,
    output logic                rsp_valid,
    output logic [len_data-1:0] rsp_rdata,
    output logic                addr_err,
    output logic                Rd,
    output logic                Wr,
    output logic [len_addr-1:0] Addr,
    output logic [len_data-1:0] In_Data,
    input  logic [len_data-1:0] Out_Data
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

    state_t              state, next_state;
    logic [1:0]          off_q;
    logic [1:0]          size_q;
    logic                we_q, uns_q, err_q;
    logic [31:0]         wdata_q, data_q;
    logic [CNT_W-1:0]    cnt;
    logic                misaligned;
    logic [4:0]          st_shift, ld_shift;
    logic [31:0]         lane_mask, merged, ld_lane, ld_ext;

    // Bit position of the addressed lane inside the 32-bit word.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
        logic [4:0] sh;
        sh = 5'd0;
`ifdef MEM_BIG_ENDIAN_EN
        if (size == 2'b00)      sh = {~off, 3'b000};
        else if (size == 2'b01) sh = {~off[1], 4'b0000};
`else
        if (size == 2'b00)      sh = {off, 3'b000};
        else if (size == 2'b01) sh = {off[1], 4'b0000};
`endif
        return sh;
    endfunction

    // Alignment check and lane arithmetic for the store merge and load extension.
    always_comb begin
        misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                     (req_size[1] && (req_addr[1:0] != 2'b00));
        st_shift   = lane_shift(size_q, off_q);
        ld_shift   = st_shift;
        lane_mask  = (size_q == 2'b00) ? (32'h0000_00FF << st_shift)
                                       : (32'h0000_FFFF << st_shift);
        merged     = (Out_Data & ~lane_mask) | ((wdata_q << st_shift) & lane_mask);
        ld_lane    = data_q >> ld_shift;
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & ld_lane[7]}}, ld_lane[7:0]};
            2'b01:   ld_ext = {{16{~uns_q & ld_lane[15]}}, ld_lane[15:0]};
            default: ld_ext = data_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (req_valid) begin
                if (misaligned)                next_state = S_DONE;
                else if (req_we && req_size[1]) next_state = S_WR;
                else                           next_state = S_RD;
            end
            S_RD:    if (cnt == '0) next_state = S_CAP;
            S_CAP:   next_state = we_q ? S_WR : S_DONE;
            S_WR:    next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Combinational outputs: stall and the response.
    always_comb begin
        stall     = req_valid && (state != S_DONE);
        rsp_valid = (state == S_DONE);
        addr_err  = (state == S_DONE) && err_q;
        rsp_rdata = (state == S_DONE && !we_q && !err_q) ? ld_ext : '0;
    end

    // Request latch, read-latency counter, capture and registered memory signals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q   <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
            cnt     <= '0;
            Rd      <= 1'b0;
            Wr      <= 1'b0;
            Addr    <= '0;
            In_Data <= '0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                off_q   <= req_addr[1:0];
                size_q  <= req_size;
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= misaligned;
                wdata_q <= req_wdata;
                cnt     <= CNT_W'(RD_LAT - 1);
                if (!misaligned) Addr <= {2'b00, req_addr[len_addr-1:2]};
            end
            if (state == S_RD && cnt != '0) cnt <= cnt - 1'b1;
            if (state == S_CAP) data_q <= Out_Data;
            Rd <= (next_state == S_RD);
            Wr <= (next_state == S_WR);
            if (next_state == S_WR)
                In_Data <= (state == S_CAP) ? merged : req_wdata;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model whose
// read data becomes valid two Rd-high posedges after Rd is first driven.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall, rsp_valid, addr_err, Rd, Wr;
    logic [31:0] rsp_rdata, Addr, In_Data, Out_Data;

    int checks = 0;
    int failures = 0;

`ifdef MEM_BIG_ENDIAN_EN
    localparam logic [31:0] E_LB0 = 32'hFFFF_FF88, E_LB = 32'hFFFF_FF99, E_LBU = 32'h0000_0099;
    localparam logic [31:0] E_LH = 32'hFFFF_AABB, E_LHU = 32'h0000_AABB;
    localparam logic [31:0] E_SB = 32'h1199_AABB, E_SB2 = 32'h1199_AA22, E_SH = 32'hDEAD_7766;
`else
    localparam logic [31:0] E_LB0 = 32'hFFFF_FFBB, E_LB = 32'hFFFF_FFAA, E_LBU = 32'h0000_00AA;
    localparam logic [31:0] E_LH = 32'hFFFF_8899, E_LHU = 32'h0000_8899;
    localparam logic [31:0] E_SB = 32'h8899_AA11, E_SB2 = 32'h2299_AA11, E_SH = 32'h7766_BEEF;
`endif

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .addr_err(addr_err), .Rd(Rd), .Wr(Wr),
        .Addr(Addr), .In_Data(In_Data), .Out_Data(Out_Data)
    );

    // Clock.
    always #5 clk = ~clk;

    // Memory model.
    logic [31:0] mem [0:15] = '{1: 32'h8899_AABB, 3: 32'h0123_4567, default: 32'h0};
    logic [3:0]  rd_cnt = '0;
    logic        both_hi = 1'b0;

    always @(posedge clk) begin
        rd_cnt <= Rd ? rd_cnt + 4'd1 : 4'd0;
        if (Wr) mem[Addr[3:0]] <= In_Data;
    end
    assign Out_Data = (rd_cnt >= 4'd2) ? mem[Addr[3:0]] : 32'hBAD0_BAD0;

    always @(negedge clk) if (Rd && Wr) both_hi = 1'b1;

    // Per-cycle trace of one access (index = cycle, 0 = accept).
    logic        rd_tr [12];
    logic        wr_tr [12];
    logic        st_tr [12];
    logic [31:0] addr_tr [12];
    logic [31:0] ind_tr [12];
    int          rsp_cyc;
    logic [31:0] rsp_data;
    logic        rsp_err;

    // Driver: issue one request and trace it until rsp_valid (bounded).
    task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        for (int i = 0; i < 12; i++) begin
            rd_tr[i] = 0; wr_tr[i] = 0; st_tr[i] = 0; addr_tr[i] = 0; ind_tr[i] = 0;
        end
        rsp_cyc = -1; rsp_data = '0; rsp_err = 1'b0;
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            rd_tr[c] = Rd; wr_tr[c] = Wr; st_tr[c] = stall;
            addr_tr[c] = Addr; ind_tr[c] = In_Data;
            if (rsp_valid) begin
                rsp_cyc = c; rsp_data = rsp_rdata; rsp_err = addr_err;
                break;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (rsp_cyc < 0) begin
            failures++;
            $display("FAIL timeout: no rsp_valid within 12 cycles (addr=%h)", addr);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({stall, rsp_valid, addr_err, Rd, Wr} !== 5'b0 || Addr !== 32'h0 ||
            In_Data !== 32'h0 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: flags=%b Addr=%h In_Data=%h rdata=%h, all required 0",
                     {stall, rsp_valid, addr_err, Rd, Wr}, Addr, In_Data, rsp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_byte;
        do_access(1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
        checks++;
        if (rsp_cyc !== 4) begin failures++; $display("FAIL lb_latency: got %0d need 4", rsp_cyc); end
        checks++;
        if (rsp_data !== E_LB) begin failures++; $display("FAIL lb_data: got %h need %h", rsp_data, E_LB); end
        checks++;
        if ({rd_tr[0], rd_tr[1], rd_tr[2], rd_tr[3]} !== 4'b0110) begin
            failures++; $display("FAIL lb_rd_window: got %b need 0110", {rd_tr[0], rd_tr[1], rd_tr[2], rd_tr[3]});
        end
        checks++;
        if (addr_tr[1] !== 32'h1) begin failures++; $display("FAIL lb_addr: got %h need 1", addr_tr[1]); end
        checks++;
        if (st_tr[0] !== 1'b1 || st_tr[3] !== 1'b1) begin
            failures++; $display("FAIL lb_stall: got %b%b need 11", st_tr[0], st_tr[3]);
        end
        do_access(1'b0, 2'b00, 1'b1, 32'h5, 32'h0);
        checks++;
        if (rsp_data !== E_LBU) begin failures++; $display("FAIL lbu_data: got %h need %h", rsp_data, E_LBU); end
        do_access(1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
        checks++;
        if (rsp_data !== E_LB0) begin failures++; $display("FAIL lb0_data: got %h need %h", rsp_data, E_LB0); end
    endtask

    task automatic test_load_half_word;
        do_access(1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
        checks++;
        if (rsp_data !== E_LH) begin failures++; $display("FAIL lh_data: got %h need %h", rsp_data, E_LH); end
        do_access(1'b0, 2'b01, 1'b1, 32'h6, 32'h0);
        checks++;
        if (rsp_data !== E_LHU) begin failures++; $display("FAIL lhu_data: got %h need %h", rsp_data, E_LHU); end
        do_access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        checks++;
        if (rsp_data !== 32'h8899_AABB || rsp_cyc !== 4) begin
            failures++; $display("FAIL lw_data: got %h@%0d need 8899aabb@4", rsp_data, rsp_cyc);
        end
    endtask

    task automatic test_store_byte;
        do_access(1'b1, 2'b00, 1'b0, 32'h4, 32'h0000_0011);
        checks++;
        if ({rd_tr[1], rd_tr[2], rd_tr[3], wr_tr[3], wr_tr[4]} !== 5'b11001) begin
            failures++; $display("FAIL sb_rd_wr_timing: got %b need 11001",
                                 {rd_tr[1], rd_tr[2], rd_tr[3], wr_tr[3], wr_tr[4]});
        end
        checks++;
        if (ind_tr[4] !== E_SB) begin failures++; $display("FAIL sb_in_data: got %h need %h", ind_tr[4], E_SB); end
        checks++;
        if (rsp_cyc !== 5 || rsp_data !== 32'h0) begin
            failures++; $display("FAIL sb_rsp: got %h@%0d need 0@5", rsp_data, rsp_cyc);
        end
        do_access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        checks++;
        if (rsp_data !== E_SB) begin failures++; $display("FAIL sb_readback: got %h need %h", rsp_data, E_SB); end
        // Upper wdata bits must not leak outside the lane.
        do_access(1'b1, 2'b00, 1'b0, 32'h7, 32'hFFFF_FF22);
        do_access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        checks++;
        if (rsp_data !== E_SB2) begin failures++; $display("FAIL sb_lane3: got %h need %h", rsp_data, E_SB2); end
    endtask

    task automatic test_store_word_half;
        do_access(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF);
        checks++;
        if (wr_tr[1] !== 1'b1 || addr_tr[1] !== 32'h2 || ind_tr[1] !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL sw_write: got Wr=%b Addr=%h In=%h need 1/2/deadbeef",
                                 wr_tr[1], addr_tr[1], ind_tr[1]);
        end
        checks++;
        if (rsp_cyc !== 2 || {st_tr[0], st_tr[1], st_tr[2]} !== 3'b110 || rd_tr[1] !== 1'b0) begin
            failures++; $display("FAIL sw_timing: got rsp@%0d stall=%b Rd=%b need 2/110/0",
                                 rsp_cyc, {st_tr[0], st_tr[1], st_tr[2]}, rd_tr[1]);
        end
        do_access(1'b1, 2'b01, 1'b0, 32'hA, 32'hFFFF_7766);
        do_access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        checks++;
        if (rsp_data !== E_SH) begin failures++; $display("FAIL sh_merge: got %h need %h", rsp_data, E_SH); end
        do_access(1'b0, 2'b01, 1'b0, 32'hA, 32'h0);
        checks++;
        if (rsp_data !== 32'h0000_7766) begin failures++; $display("FAIL lh_positive: got %h need 00007766", rsp_data); end
    endtask

    task automatic test_misaligned;
        logic any_mem;
        do_access(1'b1, 2'b01, 1'b0, 32'h5, 32'h1234);
        any_mem = 1'b0;
        for (int i = 0; i < 12; i++) any_mem |= rd_tr[i] | wr_tr[i];
        checks++;
        if (rsp_cyc !== 1 || rsp_err !== 1'b1 || any_mem !== 1'b0) begin
            failures++; $display("FAIL sh_misaligned: got rsp@%0d err=%b traffic=%b need 1/1/0",
                                 rsp_cyc, rsp_err, any_mem);
        end
        do_access(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        checks++;
        if (rsp_cyc !== 1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
            failures++; $display("FAIL lw_misaligned: got rsp@%0d err=%b data=%h need 1/1/0",
                                 rsp_cyc, rsp_err, rsp_data);
        end
        do_access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        checks++;
        if (rsp_err !== 1'b0 || rsp_data !== E_SB2 || rsp_cyc !== 4) begin
            failures++; $display("FAIL after_err_lw: got err=%b %h@%0d need 0/%h@4",
                                 rsp_err, rsp_data, rsp_cyc, E_SB2);
        end
    endtask

    task automatic test_back_to_back;
        int first_rsp, second_rsp;
        logic st3;
        logic [31:0] d;
        first_rsp = -1; second_rsp = -1; st3 = 1'b0; d = '0;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c == 3) st3 = stall;
            if (rsp_valid && first_rsp < 0) begin
                first_rsp = c;
                req_we = 1'b0; req_addr = 32'h10; req_wdata = '0;
            end else if (rsp_valid) begin
                second_rsp = c; d = rsp_rdata;
                break;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (first_rsp !== 2 || second_rsp !== 7 || st3 !== 1'b1 || d !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL back_to_back: got rsp@%0d,%0d stall3=%b data=%h need 2,7/1/cafef00d",
                                 first_rsp, second_rsp, st3, d);
        end
    endtask

    task automatic test_reset_mid_access;
        logic rd_before;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'hC; req_wdata = 32'h55; req_valid = 1'b1;
        @(negedge clk);
        #1 rd_before = Rd;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_before !== 1'b1 || Rd !== 1'b0 || Wr !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL reset_mid: got Rd_before=%b Rd=%b Wr=%b rsp=%b need 1/0/0/0",
                                 rd_before, Rd, Wr, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (mem[3] !== 32'h0123_4567) begin
            failures++; $display("FAIL reset_mem_kept: got %h need 01234567", mem[3]);
        end
        do_access(1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
        checks++;
        if (rsp_data !== 32'h0123_4567 || rsp_cyc !== 4) begin
            failures++; $display("FAIL reset_recover_lw: got %h@%0d need 01234567@4", rsp_data, rsp_cyc);
        end
    endtask

    task automatic test_exclusive;
        checks++;
        if (both_hi !== 1'b0) begin failures++; $display("FAIL rd_wr_exclusive: got both-high=%b need 0", both_hi); end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half_word();
        test_store_byte();
        test_store_word_half();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_access();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
